// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: register word offsets, STATUS
// bit positions and the UART transmitter state encoding.
package mmio_pkg;

    // Word offsets (Address[4:2]) inside the MMIO window
    localparam logic [2:0] OFF_LED       = 3'd0;
    localparam logic [2:0] OFF_UART_DATA = 3'd1;
    localparam logic [2:0] OFF_STATUS    = 3'd2;
    localparam logic [2:0] OFF_TIMER     = 3'd3;
    localparam logic [2:0] OFF_TIMER_CMP = 3'd4;

    // STATUS register bit positions
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_OVERRUN = 1;
    localparam int STATUS_MATCH   = 2;

    // Compare value out of reset: far away from the counter's start value
    localparam logic [31:0] TIMER_CMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // Packs the three status flags into the 32-bit STATUS read value
    function automatic logic [31:0] status_word(input logic busy,
                                                input logic overrun,
                                                input logic match);
        logic [31:0] w;
        w                 = '0;
        w[STATUS_BUSY]    = busy;
        w[STATUS_OVERRUN] = overrun;
        w[STATUS_MATCH]   = match;
        return w;
    endfunction

endpackage

// File: rtl/mmio_bridge_uart_tx_8n1.sv
// 8N1 serial transmitter, LSB first. A start pulse is only honoured while
// idle; the caller decides what to do with requests made while busy.
module uart_tx_8n1
    import mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state;
    uart_state_t       state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign busy      = (state != UART_IDLE);

    // State register
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UART_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: each non-idle state lasts whole bit periods
    // NOTE: the default assignment first keeps every path driven, so no
    // latch is inferred for state_next.
    always_comb begin
        state_next = state;
        case (state)
            UART_IDLE:  if (start)                        state_next = UART_START;
            UART_START: if (baud_last)                    state_next = UART_DATA;
            UART_DATA:  if (baud_last && bit_cnt == 3'd7) state_next = UART_STOP;
            UART_STOP:  if (baud_last)                    state_next = UART_IDLE;
            default:                                      state_next = UART_IDLE;
        endcase
    end

    // Baud counter: runs in every non-idle state, wraps at the bit period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (state == UART_IDLE || baud_last) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Bit counter: advances once per data bit period, wraps 7 -> 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (state != UART_DATA) begin
            bit_cnt <= '0;
        end else if (baud_last) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Shift register: captured on accept, shifted right after each data bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (state == UART_IDLE && start) begin
            shift_reg <= data;
        end else if (state == UART_DATA && baud_last) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

    // Line level per state; idle and stop drive the mark level
    always_comb begin
        tx = 1'b1;
        case (state)
            UART_START: tx = 1'b0;
            UART_DATA:  tx = shift_reg[0];
            default:    tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/mmio_bridge.sv
// Memory-port bridge: splits core accesses between the unified RAM and a
// small MMIO block (LED, UART, timer) while keeping the one-cycle read
// latency the core expects.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [3:0] MMIO_NIBBLE  = 4'h1,
    parameter int         LED_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Address,
    input  logic [31:0]      WriteData,
    input  logic             MemWrite,
    output logic [31:0]      ReadData,
    input  logic [31:0]      RamReadData,
    output logic             RamWE,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx,
    output logic             irq_timer
);

    logic        mmio_sel;
    logic [2:0]  offset;
    logic        mmio_wr;
    logic        wr_led;
    logic        wr_uart;
    logic        wr_status;
    logic        wr_timer;
    logic        wr_cmp;

    logic        uart_busy;
    logic        uart_start;
    logic        overrun;
    logic        overrun_set;
    logic        overrun_clr;
    logic        match;
    logic        match_set;
    logic        match_clr;

    logic [31:0] timer;
    logic [31:0] timer_cmp;

    logic        sel_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_next;

    // Address bits that play no part in the decode
    logic        unused_addr;
    assign unused_addr = ^{Address[27:5], Address[1:0]};

    // Decode
    assign mmio_sel  = (Address[31:28] == MMIO_NIBBLE);
    assign offset    = Address[4:2];
    assign mmio_wr   = MemWrite && mmio_sel;
    assign RamWE     = MemWrite && !mmio_sel;

    assign wr_led    = mmio_wr && (offset == OFF_LED);
    assign wr_uart   = mmio_wr && (offset == OFF_UART_DATA);
    assign wr_status = mmio_wr && (offset == OFF_STATUS);
    assign wr_timer  = mmio_wr && (offset == OFF_TIMER);
    assign wr_cmp    = mmio_wr && (offset == OFF_TIMER_CMP);

    // UART acceptance: a store while a frame is in flight is an overrun
    assign uart_start  = wr_uart && !uart_busy;
    assign overrun_set = wr_uart && uart_busy;
    assign overrun_clr = wr_status && WriteData[STATUS_OVERRUN];

    // Timer compare uses the counter value before this cycle's increment
    assign match_set   = (timer == timer_cmp);
    assign match_clr   = wr_status && WriteData[STATUS_MATCH];

    assign irq_timer   = match;

    uart_tx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .reset (reset),
        .start (uart_start),
        .data  (WriteData[7:0]),
        .tx    (uart_tx),
        .busy  (uart_busy)
    );

    // LED register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds <= '0;
        end else if (wr_led) begin
            leds <= WriteData[LED_W-1:0];
        end
    end

    // Sticky status flags; a set event outranks a same-cycle W1C clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
            match   <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (match_set) begin
                match <= 1'b1;
            end else if (match_clr) begin
                match <= 1'b0;
            end
        end
    end

    // Free-running counter; a software load replaces this cycle's increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (wr_timer) begin
            timer <= WriteData;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // Compare register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_cmp <= TIMER_CMP_RESET;
        end else if (wr_cmp) begin
            timer_cmp <= WriteData;
        end
    end

    // Register read mux on the current offset; unmapped offsets read zero
    always_comb begin
        rdata_next = '0;
        case (offset)
            OFF_LED:       rdata_next = 32'(leds);
            OFF_STATUS:    rdata_next = status_word(uart_busy, overrun, match);
            OFF_TIMER:     rdata_next = timer;
            OFF_TIMER_CMP: rdata_next = timer_cmp;
            default:       rdata_next = '0;
        endcase
    end

    // Read pipeline stage matching the RAM's one-cycle latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            sel_q   <= mmio_sel;
            rdata_q <= rdata_next;
        end
    end

    assign ReadData = sel_q ? rdata_q : RamReadData;

endmodule
